mux_bus_arbiter: RTL and testbench
==================================

// Module: mux_bus_arbiter
// PURPOSE
//  Round-robin arbiter sharing the processor's 4-way 8-bit operand mux between four requesters
//  (e.g. register file, immediate, ALU result, memory read).
//  Grants one requester at a time, drives the mux's 2-bit select, and limits each tenure to
//  MAX_HOLD consecutive cycles.
//  Sits beside the 4:1 mux; its sel output connects directly to the mux control input.
// PARAMETERS
//  MAX_HOLD  4  max consecutive cycles one requester may own the bus; legal range >= 1
//  CNT_W     3  width of the hold counter; must hold MAX_HOLD (default $clog2(MAX_HOLD+1))
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  rst        in   1      synchronous reset, active high
//  req        in   4      per-requester request; bit i = requester i; level-sensitive
//  gnt        out  4      one-hot grant, registered; 0000 when the bus is idle
//  sel        out  2      mux select = index of the granted requester, registered
//  bus_valid  out  1      1 when gnt is non-zero (mux output is owned this cycle)
// BEHAVIOUR
//  - All outputs are registered. A grant decision made at edge N is visible after edge N.
//  - Reset (rst=1 at an edge): gnt=0000, sel=00, bus_valid=0, state=IDLE, hold_cnt=0, ptr=0.
//    Reset overrides every other event. A grant in progress is dropped at that edge.
//  - ptr (2 bit) is the round-robin start index. Search order is ptr, ptr+1, ptr+2, ptr+3,
//    modulo 4. On every new grant to index w, ptr <= w+1 (mod 4).
//  - State IDLE: if req==0, stay IDLE and outputs stay at 0 (sel keeps its last value).
//    Otherwise grant the first set bit in search order:
//    gnt<=onehot(w), sel<=w, bus_valid<=1, hold_cnt<=1, go to BUSY.
//  - State BUSY, owner k:
//    * Continue when req[k]==1 and hold_cnt<MAX_HOLD: keep gnt/sel, hold_cnt<=hold_cnt+1.
//    * Release when req[k]==0 or hold_cnt==MAX_HOLD. Search the current req from ptr (=k+1).
//      - Any other requester set: grant it at the next edge with no idle bubble; hold_cnt<=1.
//      - Only req[k] still set (expiry case): re-grant k; gnt stays 1-hot(k), hold_cnt<=1,
//        ptr<=k+1.
//      - req==0: go to IDLE; gnt<=0000, bus_valid<=0, hold_cnt<=0, sel unchanged.
//  - Requests that rise or fall in the same cycle as a release are evaluated on that cycle's
//    sampled req.
//  - MAX_HOLD=1: every grant lasts exactly 1 cycle, giving strict per-cycle rotation among
//    active requesters.
//  - Invariants: gnt is always one-hot or zero; sel==index(gnt) whenever bus_valid=1;
//    bus_valid==|gnt.
//  - hold_cnt never exceeds MAX_HOLD and never wraps.
// TESTING
//  1. Assert rst for 2 cycles with req=1111 -> gnt=0000, sel=00, bus_valid=0 throughout.
//  2. After reset, set req=0100 -> one edge later gnt=0100, sel=10, bus_valid=1; ptr becomes 3.
//  3. Hold req=1111 with MAX_HOLD=4 -> gnt is 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001;
//     no idle cycles.
//  4. Owner 1 with req changing 1011->1001 -> next edge gnt=1000, sel=11
//     (search starts at 2; 0 is skipped).
//  5. Hold only req=0001 for 10 cycles -> gnt=0001 every cycle; hold_cnt runs 1,2,3,4,1,2...;
//     bus_valid never drops.
//  6. Mid-tenure of requester 2, assert rst for 1 cycle with req=1111 -> gnt=0000 after that
//     edge; next edge gnt=0001 (ptr reset to 0).

Source files
------------

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for the 4:1 operand mux: one-hot grant, 2-bit select and
// a per-tenure hold limit of MAX_HOLD cycles. All outputs are registered.
module mux_bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         gnt_reg, gnt_next;
  logic [1:0]         sel_reg, sel_next;
  logic               valid_reg, valid_next;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [1:0]         ptr_reg, ptr_next;

  logic [3:0]         rot_req;
  logic               found;
  logic [1:0]         win;

  // rot_req[i] is the request at search position i, i.e. requester ptr+i (mod 4)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) begin
        found = 1'b1;
        win   = ptr_reg + 2'(i);
      end
    end
  end

  // When the owner releases, ptr already equals owner+1, so the owner itself is
  // the last candidate: it is re-granted only if nobody else is asking.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    valid_next    = valid_reg;
    hold_cnt_next = hold_cnt_reg;
    ptr_next      = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = BUSY;
          gnt_next      = 4'b0001 << win;
          sel_next      = win;
          valid_next    = 1'b1;
          hold_cnt_next = CNT_W'(1);
          ptr_next      = win + 2'd1;
        end
      end
      BUSY: begin
        if (req[sel_reg] && (hold_cnt_reg < CNT_W'(MAX_HOLD))) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end else if (found) begin
          gnt_next      = 4'b0001 << win;
          sel_next      = win;
          valid_next    = 1'b1;
          hold_cnt_next = CNT_W'(1);
          ptr_next      = win + 2'd1;
        end else begin
          state_next    = IDLE;
          gnt_next      = 4'b0000;
          valid_next    = 1'b0;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        gnt_next      = 4'b0000;
        valid_next    = 1'b0;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= 4'b0000;
      sel_reg      <= 2'b00;
      valid_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      ptr_reg      <= 2'b00;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      valid_reg    <= valid_next;
      hold_cnt_reg <= hold_cnt_next;
      ptr_reg      <= ptr_next;
    end
  end

  assign gnt       = gnt_reg;
  assign sel       = sel_reg;
  assign bus_valid = valid_reg;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: directed scenarios plus random request traffic,
// every cycle compared against an integer-level round-robin model.
module tb_mux_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current owner (-1 when idle), cycles owned, next start index
  int owner  = -1;
  int tenure = 0;
  int start  = 0;
  int last_sel = 0;

  mux_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      owner = -1; tenure = 0; start = 0; last_sel = 0;
    end else if (owner >= 0 && r[owner] && tenure < MAX_HOLD) begin
      tenure++;
    end else begin
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && r[(start + i) % 4]) w = (start + i) % 4;
      end
      if (w >= 0) begin
        owner = w; tenure = 1; start = (w + 1) % 4; last_sel = w;
      end else begin
        owner = -1; tenure = 0;
      end
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare after the edge
  task automatic step(input logic [3:0] r, input logic rs);
    int exp_gnt;
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    exp_gnt = (owner < 0) ? 0 : (1 << owner);
    check("gnt", int'(gnt), exp_gnt);
    check("sel", int'(sel), last_sel);
    check("bus_valid", int'(bus_valid), (owner < 0) ? 0 : 1);
    check("valid_eq_or_gnt", int'(bus_valid), int'(|gnt));
    check("gnt_onehot0", int'($onehot0(gnt)), 1);
    $display("t=%0t rst=%b req=%b gnt=%b sel=%0d bus_valid=%b", $time, rs, r, gnt, sel, bus_valid);
  endtask

  initial begin
    // Reset held two cycles with all requests up
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check("reset_gnt_const", int'(gnt), 0);

    // Single request from reset; ptr moves to 3
    step(4'b0100, 1'b0);
    check("first_gnt_const", int'(gnt), 4);
    check("first_sel_const", int'(sel), 2);

    // Full contention from a clean reset: 4 cycles each, no bubbles
    step(4'b1111, 1'b1);
    for (int i = 0; i < 17; i++) step(4'b1111, 1'b0);
    check("rotation_wrap_const", int'(gnt), 1);

    // Owner 1 drops while 0 and 3 request: search starts at 2, so 3 wins
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b1011, 1'b0);
    step(4'b1001, 1'b0);
    check("skip_zero_const", int'(gnt), 8);
    check("skip_zero_sel", int'(sel), 3);

    // Lone requester re-granted after each expiry, never idle
    step(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0001, 1'b0);
    check("lone_hold_const", int'(bus_valid), 1);

    // Reset in the middle of requester 2's tenure
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    check("post_reset_gnt_const", int'(gnt), 1);

    // Release to idle keeps sel
    step(4'b0000, 1'b0);
    check("idle_after_release", int'(bus_valid), 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] r;
      logic       rs;
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      rs = ($urandom_range(0, 60) == 0);
      step(r, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
